// File: rtl/mips_sys_pkg.sv
// Shared types and constants for the multi-core MIPS run controller and checker.
package mips_sys_pkg;

    localparam int WORD = 32;

    typedef enum logic [2:0] {
        S_RST     = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    function automatic logic is_terminal(input state_t s);
        return (s == S_PASS) || (s == S_FAIL) || (s == S_TIMEOUT);
    endfunction

endpackage

// File: rtl/multicore_run_checker_store_match.sv
// Per-core decoder for the "test complete" store: flags a matching or a wrong
// value written to the completion address.
module store_match
    import mips_sys_pkg::*;
#(
    parameter logic [WORD-1:0] EXP_ADDR = 32'd84,
    parameter logic [WORD-1:0] EXP_DATA = 32'd7
) (
    input  logic            we,
    input  logic [WORD-1:0] a,
    input  logic [WORD-1:0] d,
    output logic            good,
    output logic            bad
);

    logic addr_hit_s;

    assign addr_hit_s = we & (a == EXP_ADDR);
    assign good       = addr_hit_s & (d == EXP_DATA);
    assign bad        = addr_hit_s & (d != EXP_DATA);

endmodule

// File: rtl/multicore_run_checker.sv
// Run controller: pulses the cores' reset, then watches every core for the
// completion store and reports pass / fail / timeout.
module multicore_run_checker
    import mips_sys_pkg::*;
#(
    parameter int              NCORES       = 2,
    parameter int              RST_CYCLES   = 2,
    parameter logic [WORD-1:0] EXP_ADDR     = 32'd84,
    parameter logic [WORD-1:0] EXP_DATA     = 32'd7,
    parameter logic [WORD-1:0] TIMEOUT      = 32'd1000,
    parameter int              HALT_ON_DONE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCORES-1:0]      memwrite,
    input  logic [WORD*NCORES-1:0] dataadr,
    input  logic [WORD*NCORES-1:0] writedata,
    output logic                   cpu_reset,
    output logic                   done,
    output logic                   pass,
    output logic [NCORES-1:0]      hit_mask,
    output logic [NCORES-1:0]      bad_mask,
    output logic [WORD-1:0]        cycles
);

    localparam logic [7:0]      RST_LAST  = 8'(RST_CYCLES - 1);
    localparam logic [WORD-1:0] TO_LAST   = TIMEOUT - 32'd1;
    localparam logic [WORD-1:0] CYC_MAX   = 32'hFFFF_FFFF;
    localparam logic            HALT_BIT  = (HALT_ON_DONE != 0);

    state_t            state_r;
    state_t            next_state_s;
    logic [7:0]        rst_cnt_r;
    logic [7:0]        next_rst_cnt_s;
    logic [WORD-1:0]   next_cycles_s;
    logic [NCORES-1:0] next_hit_s;
    logic [NCORES-1:0] next_bad_s;
    logic [NCORES-1:0] good_s;
    logic [NCORES-1:0] bad_s;

    for (genvar i = 0; i < NCORES; i++) begin : g_match
        store_match #(
            .EXP_ADDR (EXP_ADDR),
            .EXP_DATA (EXP_DATA)
        ) u_match (
            .we   (memwrite[i]),
            .a    (dataadr[WORD*i +: WORD]),
            .d    (writedata[WORD*i +: WORD]),
            .good (good_s[i]),
            .bad  (bad_s[i])
        );
    end

    // Next-state, counter and sticky-mask computation; decisions use masks that
    // already include this cycle's stores so simultaneous events resolve at once.
    always_comb begin
        next_state_s   = state_r;
        next_rst_cnt_s = rst_cnt_r;
        next_cycles_s  = cycles;
        next_hit_s     = hit_mask;
        next_bad_s     = bad_mask;
        case (state_r)
            S_RST: begin
                next_rst_cnt_s = rst_cnt_r + 8'd1;
                if (rst_cnt_r == RST_LAST) begin
                    next_state_s = S_RUN;
                end else begin
                    next_state_s = S_RST;
                end
            end
            S_RUN: begin
                next_hit_s = hit_mask | good_s;
                next_bad_s = bad_mask | bad_s;
                if (cycles == CYC_MAX) begin
                    next_cycles_s = cycles;
                end else begin
                    next_cycles_s = cycles + 32'd1;
                end
                if (|next_bad_s) begin
                    next_state_s = S_FAIL;
                end else if (&next_hit_s) begin
                    next_state_s = S_PASS;
                end else if (cycles == TO_LAST) begin
                    next_state_s = S_TIMEOUT;
                end else begin
                    next_state_s = S_RUN;
                end
            end
            S_PASS, S_FAIL, S_TIMEOUT: begin
                next_state_s = state_r;
            end
            default: begin
                next_state_s = S_RST;
            end
        endcase
    end

    // State, counters, masks and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_RST;
            rst_cnt_r <= 8'd0;
            cycles    <= 32'd0;
            hit_mask  <= '0;
            bad_mask  <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            rst_cnt_r <= next_rst_cnt_s;
            cycles    <= next_cycles_s;
            hit_mask  <= next_hit_s;
            bad_mask  <= next_bad_s;
            // cpu_reset follows the current state so the core reset spans
            // RST_CYCLES full cycles after the release edge.
            cpu_reset <= (state_r == S_RST) || (is_terminal(state_r) && HALT_BIT);
            done      <= is_terminal(next_state_s);
            pass      <= (next_state_s == S_PASS);
        end
    end

endmodule

// File: tb/tb_multicore_run_checker.sv
// Directed, table-driven bench: a default instance and a TIMEOUT=20,
// HALT_ON_DONE=0 instance share the same clock and stimulus.
module tb_multicore_run_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  memwrite;
    logic [63:0] dataadr;
    logic [63:0] writedata;

    logic        cpu_reset_a, done_a, pass_a;
    logic [1:0]  hit_a, bad_a;
    logic [31:0] cycles_a;
    logic        cpu_reset_b, done_b, pass_b;
    logic [1:0]  hit_b, bad_b;
    logic [31:0] cycles_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multicore_run_checker dut_a (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .cpu_reset(cpu_reset_a), .done(done_a),
        .pass(pass_a), .hit_mask(hit_a), .bad_mask(bad_a), .cycles(cycles_a)
    );

    multicore_run_checker #(.TIMEOUT(32'd20), .HALT_ON_DONE(0)) dut_b (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .cpu_reset(cpu_reset_b), .done(done_b),
        .pass(pass_b), .hit_mask(hit_b), .bad_mask(bad_b), .cycles(cycles_b)
    );

    typedef struct {
        int          cyc;
        int          core;
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;

    typedef struct {
        logic [1:0]  hit;
        logic [1:0]  bad;
        logic        done;
        logic        pass;
        logic [31:0] cycles;
        logic        cpu_reset;
    } exp_t;

    typedef struct {
        wr_t  w0;
        wr_t  w1;
        wr_t  w2;
        exp_t ea;
        exp_t eb;
    } scn_t;

    scn_t scn[8];

    function automatic wr_t mk_wr(int cyc, int core, logic [31:0] adr, logic [31:0] dat);
        wr_t w;
        w.cyc = cyc; w.core = core; w.adr = adr; w.dat = dat;
        return w;
    endfunction

    function automatic exp_t mk_exp(logic [1:0] hit, logic [1:0] bad, logic dn,
                                    logic ps, logic [31:0] cyc, logic cr);
        exp_t e;
        e.hit = hit; e.bad = bad; e.done = dn; e.pass = ps;
        e.cycles = cyc; e.cpu_reset = cr;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input exp_t e);
        chk({tag, " a.hit"},       {30'd0, hit_a},       {30'd0, e.hit});
        chk({tag, " a.bad"},       {30'd0, bad_a},       {30'd0, e.bad});
        chk({tag, " a.done"},      {31'd0, done_a},      {31'd0, e.done});
        chk({tag, " a.pass"},      {31'd0, pass_a},      {31'd0, e.pass});
        chk({tag, " a.cycles"},    cycles_a,             e.cycles);
        chk({tag, " a.cpu_reset"}, {31'd0, cpu_reset_a}, {31'd0, e.cpu_reset});
    endtask

    task automatic chk_b(input string tag, input exp_t e);
        chk({tag, " b.hit"},       {30'd0, hit_b},       {30'd0, e.hit});
        chk({tag, " b.bad"},       {30'd0, bad_b},       {30'd0, e.bad});
        chk({tag, " b.done"},      {31'd0, done_b},      {31'd0, e.done});
        chk({tag, " b.pass"},      {31'd0, pass_b},      {31'd0, e.pass});
        chk({tag, " b.cycles"},    cycles_b,             e.cycles);
        chk({tag, " b.cpu_reset"}, {31'd0, cpu_reset_b}, {31'd0, e.cpu_reset});
    endtask

    task automatic idle_bus();
        memwrite  = 2'b00;
        dataadr   = 64'd0;
        writedata = 64'd0;
    endtask

    task automatic drive(input wr_t w, input int c);
        if (w.cyc == c) begin
            memwrite[w.core]            = 1'b1;
            dataadr[32*w.core +: 32]    = w.adr;
            writedata[32*w.core +: 32]  = w.dat;
        end
    endtask

    // Reset for two edges, release, and let the two reset-pulse edges pass.
    task automatic start_run();
        idle_bus();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        step();
    endtask

    initial begin
        wr_t none;
        none = mk_wr(-1, 0, 32'd0, 32'd0);
        idle_bus();
        reset = 1'b1;

        scn[0] = '{w0: mk_wr(10, 0, 32'd84, 32'd7), w1: mk_wr(15, 1, 32'd84, 32'd7), w2: none,
                   ea: mk_exp(2'b11, 2'b00, 1'b1, 1'b1, 32'd16, 1'b1),
                   eb: mk_exp(2'b11, 2'b00, 1'b1, 1'b1, 32'd16, 1'b0)};
        scn[1] = '{w0: mk_wr(12, 1, 32'd84, 32'd5), w1: mk_wr(20, 0, 32'd84, 32'd7),
                   w2: mk_wr(25, 1, 32'd84, 32'd7),
                   ea: mk_exp(2'b00, 2'b10, 1'b1, 1'b0, 32'd13, 1'b1),
                   eb: mk_exp(2'b00, 2'b10, 1'b1, 1'b0, 32'd13, 1'b0)};
        scn[2] = '{w0: mk_wr(5, 0, 32'd84, 32'd7), w1: mk_wr(5, 1, 32'd84, 32'd9), w2: none,
                   ea: mk_exp(2'b01, 2'b10, 1'b1, 1'b0, 32'd6, 1'b1),
                   eb: mk_exp(2'b01, 2'b10, 1'b1, 1'b0, 32'd6, 1'b0)};
        scn[3] = '{w0: mk_wr(3, 0, 32'd84, 32'd7), w1: mk_wr(4, 1, 32'd80, 32'd7),
                   w2: mk_wr(6, 1, 32'd85, 32'd7),
                   ea: mk_exp(2'b01, 2'b00, 1'b0, 1'b0, 32'd40, 1'b0),
                   eb: mk_exp(2'b01, 2'b00, 1'b1, 1'b0, 32'd20, 1'b0)};
        scn[4] = '{w0: mk_wr(2, 0, 32'd84, 32'd7), w1: mk_wr(19, 1, 32'd84, 32'd7), w2: none,
                   ea: mk_exp(2'b11, 2'b00, 1'b1, 1'b1, 32'd20, 1'b1),
                   eb: mk_exp(2'b11, 2'b00, 1'b1, 1'b1, 32'd20, 1'b0)};
        scn[5] = '{w0: mk_wr(4, 0, 32'd84, 32'd7), w1: mk_wr(6, 0, 32'd84, 32'd3),
                   w2: mk_wr(8, 1, 32'd84, 32'd7),
                   ea: mk_exp(2'b01, 2'b01, 1'b1, 1'b0, 32'd7, 1'b1),
                   eb: mk_exp(2'b01, 2'b01, 1'b1, 1'b0, 32'd7, 1'b0)};
        scn[6] = '{w0: mk_wr(3, 0, 32'd84, 32'd7), w1: mk_wr(7, 0, 32'd84, 32'd7), w2: none,
                   ea: mk_exp(2'b01, 2'b00, 1'b0, 1'b0, 32'd40, 1'b0),
                   eb: mk_exp(2'b01, 2'b00, 1'b1, 1'b0, 32'd20, 1'b0)};
        scn[7] = '{w0: mk_wr(4, 0, 32'h0001_0054, 32'd7), w1: mk_wr(5, 1, 32'd84, 32'h8000_0007),
                   w2: none,
                   ea: mk_exp(2'b00, 2'b10, 1'b1, 1'b0, 32'd6, 1'b1),
                   eb: mk_exp(2'b00, 2'b10, 1'b1, 1'b0, 32'd6, 1'b0)};

        // Reset values and the cpu_reset pulse; a store during the pulse is ignored.
        step();
        step();
        chk_a("rst", mk_exp(2'b00, 2'b00, 1'b0, 1'b0, 32'd0, 1'b1));
        chk_b("rst", mk_exp(2'b00, 2'b00, 1'b0, 1'b0, 32'd0, 1'b1));
        reset = 1'b0;
        step();
        chk("pulse e1 cpu_reset", {31'd0, cpu_reset_a}, 32'd1);
        memwrite  = 2'b11;
        dataadr   = {32'd84, 32'd84};
        writedata = {32'd7, 32'd7};
        step();
        idle_bus();
        chk("pulse e2 cpu_reset", {31'd0, cpu_reset_a}, 32'd1);
        chk("pulse e2 cycles", cycles_a, 32'd0);
        chk("rst-state write ignored", {30'd0, hit_a}, 32'd0);
        step();
        chk("pulse e3 cpu_reset", {31'd0, cpu_reset_a}, 32'd0);
        chk("pulse e3 cycles", cycles_a, 32'd1);
        step();
        chk("run cycles", cycles_b, 32'd2);

        // Table-driven runs of 40 cycles each.
        for (int s = 0; s < 8; s++) begin
            start_run();
            for (int c = 0; c < 40; c++) begin
                idle_bus();
                drive(scn[s].w0, c);
                drive(scn[s].w1, c);
                drive(scn[s].w2, c);
                step();
            end
            idle_bus();
            chk_a($sformatf("scn%0d", s), scn[s].ea);
            chk_b($sformatf("scn%0d", s), scn[s].eb);
        end

        // Reset in the middle of a run, then a clean rerun.
        start_run();
        for (int c = 0; c < 8; c++) begin
            idle_bus();
            if (c == 3) begin
                memwrite  = 2'b01;
                dataadr   = {32'd0, 32'd84};
                writedata = {32'd0, 32'd7};
            end
            step();
        end
        idle_bus();
        chk("midrun hit before reset", {30'd0, hit_a}, 32'd1);
        reset = 1'b1;
        step();
        chk_a("midrun reset", mk_exp(2'b00, 2'b00, 1'b0, 1'b0, 32'd0, 1'b1));
        reset = 1'b0;
        step();
        chk("rerun e1 cpu_reset", {31'd0, cpu_reset_a}, 32'd1);
        step();
        chk("rerun e2 cpu_reset", {31'd0, cpu_reset_a}, 32'd1);
        for (int c = 0; c < 10; c++) begin
            idle_bus();
            if (c == 5) begin
                memwrite  = 2'b11;
                dataadr   = {32'd84, 32'd84};
                writedata = {32'd7, 32'd7};
            end
            step();
        end
        idle_bus();
        chk_a("rerun", mk_exp(2'b11, 2'b00, 1'b1, 1'b1, 32'd6, 1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicore_run_checker.md
Name: multicore_run_checker

Overview:
- Synthesizable run controller and result checker for N-core MIPS builds (N = 1, 2, 4, ...).
- Generates the cores' reset pulse, then watches each core's data-memory write port for the "test complete" store: data EXP_DATA to address EXP_ADDR.
- Reports pass, fail or timeout per core and globally; usable in simulation and on an FPGA (status drives LEDs).
- Sits beside TopMIPSCPU-style tops and takes their memwrite/dataadr/writedata outputs.

Parameters:
- NCORES, 2: number of monitored core write ports.
- RST_CYCLES, 2: cycles cpu_reset is held high after reset deasserts; 1 to 255.
- EXP_ADDR, 32'd84: completion-store address.
- EXP_DATA, 32'd7: completion-store data.
- TIMEOUT, 1000: run cycles allowed before timeout; 1 to 2^32-1.
- HALT_ON_DONE, 1: 1 = reassert cpu_reset in any terminal state.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- memwrite  in  NCORES  per-core write strobe; bit i = core i.
- dataadr  in  32*NCORES  per-core address; core i occupies bits [32i+31:32i].
- writedata  in  32*NCORES  per-core write data; same packing as dataadr.
- cpu_reset  out  1  reset to the cores.
- done  out  1  1 in PASS, FAIL or TIMEOUT.
- pass  out  1  1 only in PASS.
- hit_mask  out  NCORES  sticky: core i stored EXP_DATA to EXP_ADDR.
- bad_mask  out  NCORES  sticky: core i stored a wrong value to EXP_ADDR.
- cycles  out  32  run-cycle count; freezes on terminal.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state = S_RST; rst_cnt = 0; cycles = 0; hit_mask = 0; bad_mask = 0; cpu_reset = 1; done = 0; pass = 0.
- All outputs are registered. Status changes appear the cycle after the causing write is sampled.
- S_RST:
  - cpu_reset = 1; rst_cnt increments each cycle.
  - When rst_cnt == RST_CYCLES-1, go to S_RUN.
  - cpu_reset is therefore high for exactly RST_CYCLES cycles after the first clk edge with reset = 0.
  - memwrite is ignored in this state.
- S_RUN:
  - cpu_reset = 0; cycles increments by 1 per cycle, saturating at 2^32-1.
  - Per core i, each cycle:
    - memwrite[i] with addr == EXP_ADDR and data == EXP_DATA: set hit_mask[i].
    - memwrite[i] with addr == EXP_ADDR and data != EXP_DATA: set bad_mask[i].
    - Writes to other addresses are ignored.
- Transition priority, evaluated on next-state masks including this cycle's events:
  1. Any bad bit set -> S_FAIL.
  2. Else all NCORES hit bits set -> S_PASS.
  3. Else cycles == TIMEOUT-1 -> S_TIMEOUT.
- Simultaneous events:
  - Good on core 0 and bad on core 1 in the same cycle -> FAIL, with both mask bits set.
  - Last hit arriving in the timeout cycle -> PASS.
- A repeat good write from an already-hit core is a no-op.
- A later bad write from an already-hit core still sets its bad bit and forces FAIL.
- Terminal states S_PASS, S_FAIL, S_TIMEOUT:
  - done = 1; pass = 1 only in S_PASS.
  - Masks and cycles freeze; all further writes are ignored.
  - cpu_reset = HALT_ON_DONE; with HALT_ON_DONE = 0 it stays 0.
  - The state is held until reset.
- Reset mid-run: any cycle with reset = 1 returns every register to its reset value next edge, clearing masks and cycles. A new run starts when reset falls.
- Width rules: address and data comparisons are full 32-bit equality, with no byte masking.

Decomposition:
- Shared package mips_sys_pkg:
  - state typedef with encodings S_RST = 0, S_RUN = 1, S_PASS = 2, S_FAIL = 3, S_TIMEOUT = 4.
  - localparam WORD = 32.
- One natural sub-module, store_match, instantiated NCORES times via generate. Per port, purely combinational:
  - good = we & (a == EXP_ADDR) & (d == EXP_DATA)
  - bad = we & (a == EXP_ADDR) & (d != EXP_DATA)
- FSM, counters and sticky masks live in the top.

Test Plan:
1. Defaults; reset high 2 cycles, then low -> cpu_reset high exactly 2 cycles after the release edge, then 0, with cycles counting from 0.
2. Core 0 writes 7 to 84 at run cycle 10; core 1 at cycle 15 -> hit_mask = 01 after cycle 10; PASS with done = 1 and pass = 1 one cycle after cycle 15; cycles frozen at 16; cpu_reset = 1.
3. Core 1 writes 5 to 84 at cycle 12, core 0 never completes -> bad_mask = 10, FAIL, pass = 0; later good writes do not change the masks.
4. Same cycle: core 0 writes 7 to 84 and core 1 writes 9 to 84 -> hit_mask = 01, bad_mask = 10, state FAIL.
5. TIMEOUT = 20, only core 0 completes; writes of 7 to address 80 are ignored -> TIMEOUT after cycles reaches 19, done = 1, pass = 0, hit_mask = 01.
6. Reset asserted at run cycle 8 after one hit -> next edge all masks = 0, cycles = 0, cpu_reset = 1. After release, the RST_CYCLES sequence repeats and a clean pass completes.
